// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory bus arbiter: access size codes, FSM state
// encodings, the IO address window tag and the requesting-port select type.
package mem_arb_pkg;

  // data_size[1:0] encodings
  localparam logic [1:0] SizeByte = 2'b00;
  localparam logic [1:0] SizeHalf = 2'b01;
  localparam logic [1:0] SizeWord = 2'b10;

  // Arbiter FSM states
  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRead  = 2'd1;
  localparam logic [1:0] StWrite = 2'd2;
  localparam logic [1:0] StGap   = 2'd3;

  // addr[17:16] value that selects IO space
  localparam logic [1:0] IO_ADDR_HI = 2'b11;

  typedef enum logic {
    PortInst = 1'b0,
    PortData = 1'b1
  } port_e;

  // Index of the last byte of an access (N-1).
  function automatic logic [1:0] size_last(input logic [1:0] size);
    case (size)
      SizeByte: return 2'd0;
      SizeHalf: return 2'd1;
      default:  return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Sign/zero extension of a 1-, 2- or 4-byte little-endian value to 32 bits.
// Ports:
//   value_i  - raw value, valid bytes in the low lanes
//   size_i   - size code (byte/half/word)
//   zext_i   - 1 = zero-extend, 0 = sign-extend
//   result_o - extended 32-bit result
module load_extend
  import mem_arb_pkg::*;
(
  input  logic [31:0] value_i,
  input  logic [1:0]  size_i,
  input  logic        zext_i,
  output logic [31:0] result_o
);

  logic sx8;
  logic sx16;

  assign sx8  = value_i[7] & ~zext_i;
  assign sx16 = value_i[15] & ~zext_i;

  always_comb begin
    result_o = value_i;
    case (size_i)
      SizeByte: result_o = {{24{sx8}}, value_i[7:0]};
      SizeHalf: result_o = {{16{sx16}}, value_i[15:0]};
      default:  result_o = value_i;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Byte-wide memory/IO bus arbiter between instruction fetch and load/store.
// Serialises 1/2/4-byte accesses into byte transactions, assembles and
// extends read data, stalls IO writes while the UART buffer is full and
// drops in-flight reads on a pipeline flush.
// Ports:
//   clk_in, rst_n_in, rdy_in, clear_in     - clock, async reset, global ready, flush
//   inst_valid/addr -> inst_ready/res      - fetch port (always 4 bytes)
//   data_valid/wr/size/addr/value          - load/store port
//   data_ready/res                         - load/store completion, extended load data
//   mem_din, mem_dout, mem_a, mem_wr       - byte bus (outputs registered, mem_wr gated)
//   io_buffer_full                         - UART TX buffer full
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned IO_GAP = 1
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        rdy_in,
  input  logic        clear_in,
  input  logic        inst_valid,
  input  logic [31:0] inst_addr,
  output logic        inst_ready,
  output logic [31:0] inst_res,
  input  logic        data_valid,
  input  logic        data_wr,
  input  logic [2:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_value,
  output logic        data_ready,
  output logic [31:0] data_res,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  localparam int unsigned GapW = (IO_GAP > 1) ? $clog2(IO_GAP) : 1;
  localparam logic [GapW-1:0] GapInit = GapW'((IO_GAP > 0) ? IO_GAP - 1 : 0);

  logic [1:0]      state_q, state_d;
  logic [1:0]      cnt_q, cnt_d;         // byte index currently on mem_a
  logic            rv_q, rv_d;           // mem_din carries a byte of this access
  logic            rd_last_q, rd_last_d; // all bytes issued, collecting the last one
  port_e           port_q, port_d;
  port_e           last_q, last_d;       // port served most recently
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     val_q, val_d;
  logic [1:0]      nlast_q, nlast_d;
  logic [1:0]      size_q, size_d;
  logic            zext_q, zext_d;
  logic [GapW-1:0] gap_q, gap_d;
  logic [31:0]     asm_q, asm_d;
  logic [31:0]     mem_a_q, mem_a_d;
  logic [7:0]      mem_dout_q, mem_dout_d;
  logic            mem_wr_q, mem_wr_d;
  logic            inst_ready_q, inst_ready_d;
  logic            data_ready_q, data_ready_d;
  logic [31:0]     inst_res_q, inst_res_d;
  logic [31:0]     data_res_q, data_res_d;

  logic            grant_data;
  logic            grant_inst;
  logic            wr_io;
  logic            io_stall;
  logic [1:0]      lane;
  logic [31:0]     ext_val;

  assign wr_io    = (mem_a_q[17:16] == IO_ADDR_HI);
  assign io_stall = wr_io & io_buffer_full;

  load_extend u_load_extend (
    .value_i  (asm_d),
    .size_i   (size_q),
    .zext_i   (zext_q),
    .result_o (ext_val)
  );

  // mem_din lags mem_a by one cycle, so it belongs to the previous byte
  // except in the final collect cycle where the address no longer advances.
  always_comb begin
    asm_d = asm_q;
    lane  = rd_last_q ? cnt_q : cnt_q - 2'd1;
    if (rdy_in && (state_q == StRead) && rv_q && !clear_in) begin
      asm_d[{lane, 3'b000} +: 8] = mem_din;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rv_d         = rv_q;
    rd_last_d    = rd_last_q;
    port_d       = port_q;
    last_d       = last_q;
    addr_d       = addr_q;
    val_d        = val_q;
    nlast_d      = nlast_q;
    size_d       = size_q;
    zext_d       = zext_q;
    gap_d        = gap_q;
    mem_a_d      = mem_a_q;
    mem_dout_d   = mem_dout_q;
    mem_wr_d     = mem_wr_q;
    inst_ready_d = inst_ready_q;
    data_ready_d = data_ready_q;
    inst_res_d   = inst_res_q;
    data_res_d   = data_res_q;
    grant_data   = 1'b0;
    grant_inst   = 1'b0;

    if (rdy_in) begin
      inst_ready_d = 1'b0;
      data_ready_d = 1'b0;
      case (state_q)
        StIdle: begin
          // A port whose ready is pulsing still holds its old request; skip it.
          if (!clear_in) begin
            grant_data = data_valid && !data_ready_q &&
                         (!inst_valid || inst_ready_q || (last_q == PortInst));
            grant_inst = inst_valid && !inst_ready_q && !grant_data;
          end
          cnt_d     = 2'd0;
          rv_d      = 1'b0;
          rd_last_d = 1'b0;
          if (grant_data) begin
            port_d  = PortData;
            last_d  = PortData;
            addr_d  = data_addr;
            val_d   = data_value;
            nlast_d = size_last(data_size[1:0]);
            size_d  = data_size[1:0];
            zext_d  = data_size[2];
            mem_a_d = data_addr;
            if (data_wr) begin
              state_d    = StWrite;
              mem_dout_d = data_value[7:0];
              mem_wr_d   = 1'b1;
            end else begin
              state_d = StRead;
            end
          end else if (grant_inst) begin
            port_d  = PortInst;
            last_d  = PortInst;
            addr_d  = inst_addr;
            nlast_d = 2'd3;
            size_d  = SizeWord;
            zext_d  = 1'b1;
            mem_a_d = inst_addr;
            state_d = StRead;
          end
        end
        StRead: begin
          if (clear_in) begin
            state_d = StIdle;
          end else if (rd_last_q) begin
            state_d = StIdle;
            if (port_q == PortData) begin
              data_ready_d = 1'b1;
              data_res_d   = ext_val;
            end else begin
              inst_ready_d = 1'b1;
              inst_res_d   = asm_d;
            end
          end else if (cnt_q == nlast_q) begin
            rd_last_d = 1'b1;
            rv_d      = 1'b1;
          end else begin
            cnt_d   = cnt_q + 2'd1;
            mem_a_d = addr_q + {30'd0, cnt_d};
            rv_d    = 1'b1;
          end
        end
        StWrite: begin
          if (!io_stall) begin
            if (cnt_q == nlast_q) begin
              mem_wr_d     = 1'b0;
              data_ready_d = 1'b1;
              if (wr_io && (IO_GAP != 0)) begin
                state_d = StGap;
                gap_d   = GapInit;
              end else begin
                state_d = StIdle;
              end
            end else begin
              cnt_d      = cnt_q + 2'd1;
              mem_a_d    = addr_q + {30'd0, cnt_d};
              mem_dout_d = val_q[{cnt_d, 3'b000} +: 8];
            end
          end
        end
        StGap: begin
          if (gap_q == '0) begin
            state_d = StIdle;
          end else begin
            gap_d = gap_q - GapW'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= StIdle;
      cnt_q        <= 2'd0;
      rv_q         <= 1'b0;
      rd_last_q    <= 1'b0;
      port_q       <= PortInst;
      last_q       <= PortInst;
      addr_q       <= '0;
      val_q        <= '0;
      nlast_q      <= 2'd0;
      size_q       <= SizeByte;
      zext_q       <= 1'b0;
      gap_q        <= '0;
      asm_q        <= '0;
      mem_a_q      <= '0;
      mem_dout_q   <= '0;
      mem_wr_q     <= 1'b0;
      inst_ready_q <= 1'b0;
      data_ready_q <= 1'b0;
      inst_res_q   <= '0;
      data_res_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rv_q         <= rv_d;
      rd_last_q    <= rd_last_d;
      port_q       <= port_d;
      last_q       <= last_d;
      addr_q       <= addr_d;
      val_q        <= val_d;
      nlast_q      <= nlast_d;
      size_q       <= size_d;
      zext_q       <= zext_d;
      gap_q        <= gap_d;
      asm_q        <= asm_d;
      mem_a_q      <= mem_a_d;
      mem_dout_q   <= mem_dout_d;
      mem_wr_q     <= mem_wr_d;
      inst_ready_q <= inst_ready_d;
      data_ready_q <= data_ready_d;
      inst_res_q   <= inst_res_d;
      data_res_q   <= data_res_d;
    end
  end

  assign mem_a      = mem_a_q;
  assign mem_dout   = mem_dout_q;
  assign mem_wr     = mem_wr_q & rdy_in & ~io_stall;
  assign inst_ready = inst_ready_q;
  assign inst_res   = inst_res_q;
  assign data_ready = data_ready_q;
  assign data_res   = data_res_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a registered byte-memory model.
module tb_mem_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b1;
  logic        rdy_in = 1'b1;
  logic        clear_in = 1'b0;
  logic        inst_valid = 1'b0;
  logic [31:0] inst_addr = '0;
  logic        inst_ready;
  logic [31:0] inst_res;
  logic        data_valid = 1'b0;
  logic        data_wr = 1'b0;
  logic [2:0]  data_size = '0;
  logic [31:0] data_addr = '0;
  logic [31:0] data_value = '0;
  logic        data_ready;
  logic [31:0] data_res;
  logic [7:0]  mem_din = '0;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_in = ~clk_in;

  mem_arbiter #(.IO_GAP(1)) dut (
    .clk_in         (clk_in),
    .rst_n_in       (rst_n_in),
    .rdy_in         (rdy_in),
    .clear_in       (clear_in),
    .inst_valid     (inst_valid),
    .inst_addr      (inst_addr),
    .inst_ready     (inst_ready),
    .inst_res       (inst_res),
    .data_valid     (data_valid),
    .data_wr        (data_wr),
    .data_size      (data_size),
    .data_addr      (data_addr),
    .data_value     (data_value),
    .data_ready     (data_ready),
    .data_res       (data_res),
    .mem_din        (mem_din),
    .mem_dout       (mem_dout),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr),
    .io_buffer_full (io_buffer_full)
  );

  // Byte memory: read data appears the cycle after its address; frozen with rdy_in.
  logic [7:0] mem [logic [31:0]];

  function automatic logic [7:0] rd_mem(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 8'h00;
  endfunction

  always @(posedge clk_in) begin
    if (!rst_n_in) begin
      mem_din <= 8'h00;
      mem[32'h100] = 8'h93; mem[32'h101] = 8'h00; mem[32'h102] = 8'hA0; mem[32'h103] = 8'h00;
      mem[32'h200] = 8'h80; mem[32'h201] = 8'h11; mem[32'h202] = 8'h22;
      mem[32'h203] = 8'h33; mem[32'h204] = 8'h44;
      mem[32'h210] = 8'h01; mem[32'h211] = 8'h80;
    end else if (rdy_in) begin
      mem_din <= rd_mem(mem_a);
      if (mem_wr) mem[mem_a] = mem_dout;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  int          wcyc[$];
  logic [31:0] wadr[$];
  logic [7:0]  wdat[$];
  logic [31:0] trace_a [40];

  // One request presented in the current cycle (relative cycle 0); returns the
  // relative cycle of its ready pulse, or -1 if none arrives within the bound.
  task automatic req(input bit is_inst, input bit wr, input logic [2:0] size,
                     input logic [31:0] addr, input logic [31:0] value,
                     input int full_n, input int clr_at, input int lo_at, input int lo_n,
                     output int lat, output logic [31:0] res);
    lat = -1;
    res = '0;
    wcyc.delete();
    wadr.delete();
    wdat.delete();
    if (is_inst) begin
      inst_valid = 1'b1;
      inst_addr  = addr;
    end else begin
      data_valid = 1'b1;
      data_wr    = wr;
      data_size  = size;
      data_addr  = addr;
      data_value = value;
    end
    for (int i = 0; i < 40; i++) begin
      if (i > 0) tick();
      io_buffer_full = (full_n > 0) && (i <= full_n);
      clear_in       = (i == clr_at);
      rdy_in         = !((i >= lo_at) && (i < lo_at + lo_n));
      if ((i == clr_at) && (clr_at > 0) && !wr) begin
        if (is_inst) inst_valid = 1'b0;
        else data_valid = 1'b0;
      end
      #1;
      trace_a[i] = mem_a;
      if (mem_wr) begin
        wcyc.push_back(i);
        wadr.push_back(mem_a);
        wdat.push_back(mem_dout);
      end
      if (is_inst ? inst_ready : data_ready) begin
        lat = i;
        res = is_inst ? inst_res : data_res;
        break;
      end
    end
    if (is_inst) inst_valid = 1'b0;
    else data_valid = 1'b0;
    clear_in       = 1'b0;
    rdy_in         = 1'b1;
    io_buffer_full = 1'b0;
  endtask

  initial begin
    int          lat;
    logic [31:0] res;
    int          seen;
    logic [3:0]  order;
    int          when [4];
    logic [31:0] sw_val;

    #2 rst_n_in = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    check_eq("rst_mem_a", mem_a, 32'h0);
    check_eq("rst_mem_dout", {24'h0, mem_dout}, 32'h0);
    check_eq("rst_mem_wr", {31'h0, mem_wr}, 32'h0);
    check_eq("rst_inst_ready", {31'h0, inst_ready}, 32'h0);
    check_eq("rst_data_ready", {31'h0, data_ready}, 32'h0);
    check_eq("rst_inst_res", inst_res, 32'h0);
    check_eq("rst_data_res", data_res, 32'h0);
    rst_n_in = 1'b1;
    idle(2);

    // Fetch word
    req(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 0, -1, 0, 0, lat, res);
    check_eq("fetch_lat", lat, 32'd6);
    check_eq("fetch_res", res, 32'h00A00093);
    for (int k = 0; k < 4; k++) check_eq("fetch_addr", trace_a[k+1], 32'h100 + k);
    idle(1);

    // Loads with extension
    req(1'b0, 1'b0, 3'b000, 32'h200, 32'h0, 0, -1, 0, 0, lat, res);
    check_eq("lb_lat", lat, 32'd3);
    check_eq("lb_res", res, 32'hFFFFFF80);
    idle(1);
    req(1'b0, 1'b0, 3'b100, 32'h200, 32'h0, 0, -1, 0, 0, lat, res);
    check_eq("lbu_res", res, 32'h00000080);
    idle(1);
    req(1'b0, 1'b0, 3'b001, 32'h210, 32'h0, 0, -1, 0, 0, lat, res);
    check_eq("lh_lat", lat, 32'd4);
    check_eq("lh_res", res, 32'hFFFF8001);
    idle(1);
    req(1'b0, 1'b0, 3'b101, 32'h210, 32'h0, 0, -1, 0, 0, lat, res);
    check_eq("lhu_res", res, 32'h00008001);
    idle(1);
    req(1'b0, 1'b0, 3'b010, 32'h201, 32'h0, 0, -1, 0, 0, lat, res);
    check_eq("lw_unal_lat", lat, 32'd6);
    check_eq("lw_unal_res", res, 32'h44332211);
    idle(1);
    req(1'b0, 1'b0, 3'b000, 32'h201, 32'h0, 0, -1, 0, 0, lat, res);
    check_eq("lb_pos_res", res, 32'h00000011);
    idle(1);

    // RAM store word, then a fetch granted in the store's ready cycle
    sw_val = 32'h11223344;
    req(1'b0, 1'b1, 3'b010, 32'h300, sw_val, 0, -1, 0, 0, lat, res);
    check_eq("sw_lat", lat, 32'd5);
    check_eq("sw_nwr", wcyc.size(), 32'd4);
    for (int k = 0; k < 4 && k < wcyc.size(); k++) begin
      check_eq("sw_cyc", wcyc[k], k + 1);
      check_eq("sw_addr", wadr[k], 32'h300 + k);
      check_eq("sw_data", {24'h0, wdat[k]}, (sw_val >> (8 * k)) & 32'hFF);
    end
    req(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 0, -1, 0, 0, lat, res);
    check_eq("fetch_after_sw_lat", lat, 32'd6);
    check_eq("data_res_hold", data_res, 32'h00000011);
    idle(1);

    // IO byte store with buffer full for 3 cycles, then GAP delays next fetch
    req(1'b0, 1'b1, 3'b000, 32'h30000, 32'h41, 3, -1, 0, 0, lat, res);
    check_eq("io_sb_lat", lat, 32'd5);
    check_eq("io_sb_nwr", wcyc.size(), 32'd1);
    if (wcyc.size() > 0) begin
      check_eq("io_sb_cyc", wcyc[0], 32'd4);
      check_eq("io_sb_addr", wadr[0], 32'h30000);
      check_eq("io_sb_data", {24'h0, wdat[0]}, 32'h41);
    end
    req(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 0, -1, 0, 0, lat, res);
    check_eq("fetch_after_gap_lat", lat, 32'd7);
    idle(1);

    // Round-robin with both requests held
    data_valid = 1'b1; data_wr = 1'b0; data_size = 3'b000; data_addr = 32'h200;
    inst_valid = 1'b1; inst_addr = 32'h100;
    seen = 0;
    order = '0;
    for (int k = 0; k < 4; k++) when[k] = -1;
    for (int i = 0; i < 60 && seen < 4; i++) begin
      if (i > 0) tick();
      #1;
      if (data_ready && seen < 4) begin order[seen] = 1'b1; when[seen] = i; seen++; end
      if (inst_ready && seen < 4) begin order[seen] = 1'b0; when[seen] = i; seen++; end
    end
    data_valid = 1'b0;
    inst_valid = 1'b0;
    check_eq("rr_count", seen, 32'd4);
    check_eq("rr_order", {28'h0, order}, 32'h5);
    check_eq("rr_inst1_cyc", when[1], 32'd9);
    check_eq("rr_data2_cyc", when[2], 32'd12);
    idle(1);

    // Flush during fetch: no ready, FSM idle again
    req(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 0, 2, 0, 0, lat, res);
    check_eq("flush_fetch_lat", lat, 32'hFFFFFFFF);
    check_eq("flush_inst_res_hold", inst_res, 32'h00A00093);
    idle(1);
    req(1'b0, 1'b0, 3'b000, 32'h200, 32'h0, 0, -1, 0, 0, lat, res);
    check_eq("post_flush_lat", lat, 32'd3);
    check_eq("post_flush_res", res, 32'hFFFFFF80);
    idle(2);

    // Request in the same cycle as a flush is not granted
    req(1'b0, 1'b0, 3'b000, 32'h200, 32'h0, 0, 0, 0, 0, lat, res);
    check_eq("clr_grant_lat", lat, 32'd4);
    idle(1);

    // Flush mid-store: store completes
    req(1'b0, 1'b1, 3'b010, 32'h400, 32'hA1B2C3D4, 0, 2, 0, 0, lat, res);
    check_eq("clr_sw_lat", lat, 32'd5);
    check_eq("clr_sw_nwr", wcyc.size(), 32'd4);
    check_eq("clr_sw_mem", {rd_mem(32'h403), rd_mem(32'h402), rd_mem(32'h401), rd_mem(32'h400)},
             32'hA1B2C3D4);
    idle(1);

    // rdy_in low for 3 cycles mid-read
    req(1'b0, 1'b0, 3'b010, 32'h201, 32'h0, 0, -1, 3, 3, lat, res);
    check_eq("stall_lw_lat", lat, 32'd9);
    check_eq("stall_lw_res", res, 32'h44332211);
    idle(1);

    // rdy_in low for 2 cycles mid-store
    req(1'b0, 1'b1, 3'b010, 32'h500, 32'h55667788, 0, -1, 2, 2, lat, res);
    check_eq("stall_sw_lat", lat, 32'd7);
    check_eq("stall_sw_nwr", wcyc.size(), 32'd4);
    if (wcyc.size() > 1) check_eq("stall_sw_cyc1", wcyc[1], 32'd4);
    check_eq("stall_sw_mem", {rd_mem(32'h503), rd_mem(32'h502), rd_mem(32'h501), rd_mem(32'h500)},
             32'h55667788);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the CPU's single byte-wide memory/IO bus between the instruction-fetch port and the load/store data port. It serialises multi-byte accesses into byte transactions, assembles and extends read results, and holds IO writes while the UART buffer is full. It aborts speculative reads on a pipeline flush. It sits between the cache/fetch logic, the load-store buffer, and the top-level `mem_*` pins.

## Interface
- `IO_GAP`, default 1: idle cycles inserted after every IO-space write before the next transaction.
- `clk_in`  in  1  system clock.
- `rst_n_in`  in  1  asynchronous, active-low reset.
- `rdy_in`  in  1  global ready; low freezes all state.
- `clear_in`  in  1  pipeline flush (ROB mispredict).
- `inst_valid`  in  1  fetch request, held until `inst_ready`.
- `inst_addr`  in  32  fetch address, word-aligned.
- `inst_ready`  out  1  one-cycle pulse, `inst_res` valid.
- `inst_res`  out  32  fetched word, little-endian.
- `data_valid`  in  1  load/store request, held until `data_ready`.
- `data_wr`  in  1  1 = store.
- `data_size`  in  3  [1:0]: 00 byte, 01 half, 10 word; [2]=1 zero-extend load.
- `data_addr`  in  32  byte address.
- `data_value`  in  32  store data, low bytes used.
- `data_ready`  out  1  one-cycle pulse: load result valid or store done.
- `data_res`  out  32  extended load result.
- `mem_din`  in  8  memory read byte, valid the cycle after its address.
- `mem_dout`  out  8  write byte.
- `mem_a`  out  32  byte address.
- `mem_wr`  out  1  1 = write.
- `io_buffer_full`  in  1  UART TX buffer full.

## Operation
- States: IDLE, READ, WRITE, GAP.
- IDLE arbitration is round-robin. When both ports are valid, the port not served last wins. After reset, the data port wins first.
- Grant latches port, address, N (1/2/4 bytes), direction and extension mode. Requests are not re-sampled until done.
- READ: bytes k=0..N-1 present `mem_a=addr+k` on consecutive cycles. `mem_din` from cycle k+1 is placed into byte k of the result.
- Result: sign-extended from bit 8N-1 unless `data_size[2]`; fetches are always 4 bytes.
- WRITE: byte k drives `mem_a=addr+k`, `mem_dout=value[8k+7:8k]`, `mem_wr=1`. Each byte takes one cycle.
- IO space is `addr[17:16]==2'b11`. An IO write byte is not issued while `io_buffer_full` is high; the FSM stays in WRITE with `mem_wr=0` and `mem_a` held. After completion it goes to GAP for `IO_GAP` cycles, then to IDLE.
- `clear_in`: an in-flight READ, for either port, is dropped to IDLE with no ready pulse. WRITE is never aborted because stores are committed. A request presented in the same cycle as `clear_in` is not granted.
- `rdy_in` low: FSM, counters and registers hold. `mem_wr` is forced 0 combinationally. The stalled step repeats when `rdy_in` returns.
- Unaligned addresses are permitted; bytes simply increment. Address wrap at 2^32 is ignored.

## Timing
- Reset values: `mem_a=0`, `mem_dout=0`, `mem_wr=0`, `inst_ready=0`, `data_ready=0`, `inst_res=0`, `data_res=0`, state IDLE, round-robin pointer = inst-last.
- Grant at cycle 0, with the request seen in IDLE. The first byte is on the bus at cycle 1, since all bus outputs are registered.
- Read of N bytes: ready pulses at cycle N+2. The next grant can happen in that same cycle.
- Write of N bytes (RAM): `mem_wr` is high cycles 1..N, ready pulses at cycle N+1. Each IO full-stall cycle adds one cycle.
- Bus idle (`mem_wr=0`, `mem_a` holds last value) whenever the state is IDLE or GAP.
- Ready pulses are exactly one cycle. The result holds until the next ready of the same port.
- Requester must deassert `valid` in the cycle after ready, or present a new request.

## Structure
- Shared package `mem_arb_pkg`: size codes, state enum, `IO_ADDR_HI = 2'b11`, port-select enum.
- One sub-module, `load_extend`: combinational sign/zero extension of 1/2/4-byte values. It is reused by the LSB forwarding path.
- Byte counter is 2 bits; the assembly register is 32 bits, written per byte lane.

## Test plan
- Fetch word at 0x100 holding 0x00A00093 -> `mem_a` 0x100..0x103 over cycles 1-4, `inst_ready` at cycle 6 with `inst_res=0x00A00093`.
- `lb` (size 000) at 0x200 holding 0x80 -> `data_res=0xFFFFFF80`. `lbu` (size 100) -> `0x00000080`. `lh` of 0x8001 -> `0xFFFF8001`.
- `inst_valid` and `data_valid` both high, held continuously -> grants alternate data, inst, data. Neither port is starved.
- `sw` of 0x11223344 to 0x300 -> writes 44, 33, 22, 11 to 0x300..0x303 on cycles 1-4, `data_ready` at cycle 5.
- `sb` 0x41 to 0x30000 with `io_buffer_full` high for 3 cycles -> `mem_wr` low for 3 cycles, then one write cycle, then 1 GAP cycle.
- `clear_in` at cycle 2 of a fetch -> no `inst_ready`, FSM back in IDLE. `clear_in` mid-store -> all 4 bytes still written. `rdy_in` low mid-read -> same result, delayed by the pause length.
